// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - mode encodings, bar palette and timing helpers for the VGA generator
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRID  = 2'd2,
    MODE_SOLID = 2'd3
  } vga_mode_e;

  // Bar colours as {R,G,B} on/off masks; the top expands each bit to a full-scale channel.
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_mask = BAR_WHITE;
      3'd1:    bar_mask = BAR_YELLOW;
      3'd2:    bar_mask = BAR_CYAN;
      3'd3:    bar_mask = BAR_GREEN;
      3'd4:    bar_mask = BAR_MAGENTA;
      3'd5:    bar_mask = BAR_RED;
      3'd6:    bar_mask = BAR_BLUE;
      default: bar_mask = BAR_BLACK;
    endcase
  endfunction

  function automatic int h_total(input int sync, input int back, input int active, input int front);
    return sync + back + active + front;
  endfunction

  function automatic int v_total(input int sync, input int back, input int active, input int front);
    return sync + back + active + front;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth register shift chain with asynchronous clear
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// rtl/vga_timing_pattern_gen.sv - VGA timing, test patterns and pixel-source latency alignment
module vga_timing_pattern_gen
  import vga_pkg::*;
#(
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FRONT   = 16,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FRONT   = 10,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   CNT_W     = 12,
  parameter int   COLOR_W   = 8,
  parameter int   PIX_LAT   = 2,
  parameter int   GRID_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  input  logic [3*COLOR_W-1:0] ext_rgb,
  output logic                 pix_req,
  output logic [CNT_W-1:0]     pix_x,
  output logic [CNT_W-1:0]     pix_y,
  output logic                 frame_start,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_blank_n,
  output logic                 vga_sync_n,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b
);

  localparam int RGB_W   = 3 * COLOR_W;
  localparam int H_TOTAL = h_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOTAL = v_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

  localparam logic [CNT_W-1:0] H_LAST_C    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C    = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C    = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA_START_C  = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] HA_END_C    = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CNT_W-1:0] VA_START_C  = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] VA_END_C    = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [CNT_W-1:0] HA_LAST_C   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VA_LAST_C   = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] BAR_LAST_C  = CNT_W'(H_ACTIVE / 8 - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] cur_x, cur_y;
  logic             h_act, v_act, frame_top, first_px, grid_on;
  logic [CNT_W-1:0] bar_cnt, cur_bar_cnt;
  logic [2:0]       bar_idx, cur_bar_idx, bar_m;
  vga_mode_e        mode_q;
  logic [RGB_W-1:0] solid_q, pat_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST_C) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    h_act       = (h_cnt >= HA_START_C) && (h_cnt < HA_END_C);
    v_act       = (v_cnt >= VA_START_C) && (v_cnt < VA_END_C);
    cur_x       = h_cnt - HA_START_C;
    cur_y       = v_cnt - VA_START_C;
    frame_top   = (h_cnt == '0) && (v_cnt == '0);
    first_px    = (h_cnt == HA_START_C);
    cur_bar_cnt = first_px ? '0 : bar_cnt;
    cur_bar_idx = first_px ? 3'd0 : bar_idx;
    bar_m       = bar_mask(cur_bar_idx);
    grid_on     = (cur_x[GRID_LOG2-1:0] == '0) || (cur_y[GRID_LOG2-1:0] == '0) ||
                  (cur_x == HA_LAST_C) || (cur_y == VA_LAST_C);
  end

  // Bars are tracked with a run counter restarted at each line's first active pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_cnt <= '0;
      bar_idx <= 3'd0;
    end else if (h_act) begin
      if (cur_bar_cnt == BAR_LAST_C) begin
        bar_cnt <= '0;
        bar_idx <= cur_bar_idx + 3'd1;
      end else begin
        bar_cnt <= cur_bar_cnt + 1'b1;
        bar_idx <= cur_bar_idx;
      end
    end
  end

  always_comb begin
    pat_rgb = '0;
    case (mode_q)
      MODE_BARS:  pat_rgb = {{COLOR_W{bar_m[2]}}, {COLOR_W{bar_m[1]}}, {COLOR_W{bar_m[0]}}};
      MODE_GRID:  pat_rgb = grid_on ? '1 : '0;
      MODE_SOLID: pat_rgb = solid_q;
      default:    pat_rgb = '0;
    endcase
  end

  logic             hs_s, vs_s, de_s, ext_s;
  logic [RGB_W-1:0] col_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      mode_q      <= MODE_EXT;
      solid_q     <= '0;
      hs_s        <= 1'b0;
      vs_s        <= 1'b0;
      de_s        <= 1'b0;
      ext_s       <= 1'b0;
      col_s       <= '0;
    end else begin
      pix_req     <= h_act && v_act;
      pix_x       <= (h_act && v_act) ? cur_x : '0;
      pix_y       <= (h_act && v_act) ? cur_y : '0;
      frame_start <= frame_top;
      if (frame_top) begin
        mode_q  <= vga_mode_e'(mode);
        solid_q <= solid_rgb;
      end
      hs_s  <= (h_cnt < H_SYNC_C);
      vs_s  <= (v_cnt < V_SYNC_C);
      de_s  <= h_act && v_act;
      ext_s <= (mode_q == MODE_EXT);
      col_s <= pat_rgb;
    end
  end

  // Sync flags travel active-high so a cleared pipeline reads as "not in sync".
  logic             hs_d, vs_d, de_d, ext_d;
  logic [RGB_W-1:0] col_d;

  vga_delay_line #(
    .WIDTH(RGB_W + 4),
    .DEPTH(PIX_LAT)
  ) u_align (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({hs_s, vs_s, de_s, ext_s, col_s}),
    .dout ({hs_d, vs_d, de_d, ext_d, col_d})
  );

  logic [RGB_W-1:0] rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
      vga_blank_n <= 1'b0;
      rgb_q       <= '0;
    end else begin
      vga_hs      <= hs_d ? HS_POL : ~HS_POL;
      vga_vs      <= vs_d ? VS_POL : ~VS_POL;
      vga_blank_n <= de_d;
      if (!de_d)      rgb_q <= '0;
      else if (ext_d) rgb_q <= ext_rgb;
      else            rgb_q <= col_d;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// tb/tb_vga_timing_pattern_gen.sv - self-checking bench with a position-based reference model
module tb_vga_timing_pattern_gen;

  localparam int HS = 4, HB = 4, HA = 16, HF = 4;
  localparam int VS = 2, VB = 2, VA = 8, VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
  localparam int LAT = 3;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic [23:0] ext_rgb;

  logic        pix_req, frame_start, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [11:0] pix_x, pix_y;
  logic [7:0]  vga_r, vga_g, vga_b;

  logic        i_pix_req, i_frame_start, i_hs, i_vs, i_blank_n, i_sync_n;
  logic [11:0] i_pix_x, i_pix_y;
  logic [7:0]  i_r, i_g, i_b;

  always #5 clk = ~clk;

  vga_timing_pattern_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12), .COLOR_W(8), .PIX_LAT(2), .GRID_LOG2(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb), .ext_rgb(ext_rgb),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  vga_timing_pattern_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12), .COLOR_W(8), .PIX_LAT(2), .GRID_LOG2(2)
  ) u_inv (
    .clk(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb), .ext_rgb(ext_rgb),
    .pix_req(i_pix_req), .pix_x(i_pix_x), .pix_y(i_pix_y), .frame_start(i_frame_start),
    .vga_hs(i_hs), .vga_vs(i_vs), .vga_blank_n(i_blank_n), .vga_sync_n(i_sync_n),
    .vga_r(i_r), .vga_g(i_g), .vga_b(i_b)
  );

  // Two-stage external pixel source fed by the request coordinates.
  logic [23:0] src1, src2;
  always @(posedge clk) begin
    src1 <= {pix_x[7:0], pix_y[7:0], 8'h5A};
    src2 <= src1;
  end
  assign ext_rgb = src2;

  int tests = 0;
  int fails = 0;
  int n = 0;
  int last_fs = -1;
  int fs_period = 0;
  logic tally = 1'b0;
  int c_hs = 0, c_vs = 0, c_de = 0, c_fs = 0, c_ihs = 0, c_ivs = 0;
  logic [1:0]  fmode [$];
  logic [23:0] fsolid [$];

  typedef struct {
    logic [1:0]  m;
    logic [23:0] s;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  function automatic logic [23:0] pattern(input int m, input logic [23:0] s, input int x, input int y);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    case (m)
      1:       return BARS[x / (HA / 8)];
      2:       return ((x % 4 == 0) || (y % 4 == 0) || (x == HA - 1) || (y == VA - 1)) ? 24'hFFFFFF : 24'h0;
      3:       return s;
      default: return {xb, yb, 8'h5A};
    endcase
  endfunction

  function automatic int pos(input int x, input int y);
    return (VS + VB + y) * HT + HS + HB + x;
  endfunction

  task automatic tick();
    int p, h, v, q, f;
    logic act, e_hs, e_vs, e_de;
    logic [23:0] e_rgb;
    @(posedge clk);
    n++;
    if ((n - 1) % FT == 0) begin
      fmode.push_back(mode);
      fsolid.push_back(solid_rgb);
    end
    #1;
    p = (n - 1) % FT;
    h = p % HT;
    v = p / HT;
    act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    check("frame_start", 32'(frame_start), 32'(p == 0));
    check("pix_req", 32'(pix_req), 32'(act));
    check("pix_x", 32'(pix_x), act ? 32'(h - HS - HB) : 32'h0);
    check("pix_y", 32'(pix_y), act ? 32'(v - VS - VB) : 32'h0);
    check("inv_frame_start", 32'(i_frame_start), 32'(p == 0));
    check("inv_pix", {6'h0, i_pix_req, i_pix_x[11:0], i_pix_y[11:0], 1'b0},
          {6'h0, act, act ? 12'(h - HS - HB) : 12'h0, act ? 12'(v - VS - VB) : 12'h0, 1'b0});
    if (n <= LAT) begin
      e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_rgb = 24'h0;
    end else begin
      q = n - LAT - 1;
      f = q / FT;
      p = q % FT;
      h = p % HT;
      v = p / HT;
      e_hs = (h < HS);
      e_vs = (v < VS);
      e_de = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
      e_rgb = e_de ? pattern(int'(fmode[f]), fsolid[f], h - HS - HB, v - VS - VB) : 24'h0;
    end
    check("vga_hs", 32'(vga_hs), 32'(!e_hs));
    check("vga_vs", 32'(vga_vs), 32'(!e_vs));
    check("vga_blank_n", 32'(vga_blank_n), 32'(e_de));
    check("vga_rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
    check("vga_sync_n", 32'(vga_sync_n), 32'h0);
    check("inv_hs", 32'(i_hs), 32'(e_hs));
    check("inv_vs", 32'(i_vs), 32'(e_vs));
    check("inv_video", 32'({i_blank_n, i_sync_n, i_r, i_g, i_b}), 32'({e_de, 1'b0, e_rgb}));
    if (frame_start) begin
      if (last_fs >= 0) fs_period = n - last_fs;
      last_fs = n;
    end
    if (tally) begin
      if (!vga_hs) c_hs++;
      if (!vga_vs) c_vs++;
      if (vga_blank_n) c_de++;
      if (frame_start) c_fs++;
      if (i_hs) c_ihs++;
      if (i_vs) c_ivs++;
    end
  endtask

  task automatic wait_out(input int q);
    if (n > q + LAT + 1) check("schedule", 32'(n), 32'(q + LAT + 1));
    while (n < q + LAT + 1) tick();
  endtask

  function automatic int next_frame();
    return (n + FT - 1) / FT;
  endfunction

  initial begin
    int f;
    vecs[0]  = '{2'd1, 24'h0, 0,  0, 24'hFFFFFF};
    vecs[1]  = '{2'd1, 24'h0, 3,  1, 24'hFFFF00};
    vecs[2]  = '{2'd1, 24'h0, 4,  2, 24'h00FFFF};
    vecs[3]  = '{2'd1, 24'h0, 7,  3, 24'h00FF00};
    vecs[4]  = '{2'd1, 24'h0, 8,  4, 24'hFF00FF};
    vecs[5]  = '{2'd1, 24'h0, 11, 5, 24'hFF0000};
    vecs[6]  = '{2'd1, 24'h0, 12, 6, 24'h0000FF};
    vecs[7]  = '{2'd1, 24'h0, 15, 7, 24'h000000};
    vecs[8]  = '{2'd2, 24'h0, 1,  1, 24'h000000};
    vecs[9]  = '{2'd2, 24'h0, 0,  3, 24'hFFFFFF};
    vecs[10] = '{2'd2, 24'h0, 5,  4, 24'hFFFFFF};
    vecs[11] = '{2'd2, 24'h0, 15, 1, 24'hFFFFFF};
    vecs[12] = '{2'd2, 24'h0, 6,  7, 24'hFFFFFF};
    vecs[13] = '{2'd2, 24'h0, 6,  5, 24'h000000};
    vecs[14] = '{2'd3, 24'h123456, 5, 5, 24'h123456};
    vecs[15] = '{2'd0, 24'h0, 9,  6, 24'h09065A};

    mode = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hs", 32'(vga_hs), 32'h1);
    check("reset_vs", 32'(vga_vs), 32'h1);
    check("reset_out", 32'({vga_blank_n, pix_req, frame_start, vga_r, vga_g, vga_b}), 32'h0);
    check("reset_inv_sync", 32'({i_hs, i_vs}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    tally = 1'b0;
    while (n < 2 * FT + LAT) begin
      tally = (n >= FT + LAT) && (n < 2 * FT + LAT);
      tick();
    end
    tally = 1'b0;
    check("hs_low_per_frame", 32'(c_hs), 32'(HS * VT));
    check("vs_low_per_frame", 32'(c_vs), 32'(VS * HT));
    check("blank_high_per_frame", 32'(c_de), 32'(HA * VA));
    check("fs_per_frame", 32'(c_fs), 32'h1);
    check("fs_period", 32'(fs_period), 32'(FT));
    check("inv_hs_high", 32'(c_ihs), 32'(HS * VT));
    check("inv_vs_high", 32'(c_ivs), 32'(VS * HT));

    for (int i = 0; i < 16; i++) begin
      mode = vecs[i].m;
      solid_rgb = vecs[i].s;
      f = next_frame();
      wait_out(f * FT + pos(vecs[i].x, vecs[i].y));
      check("table_rgb", 32'({vga_r, vga_g, vga_b}), 32'(vecs[i].exp));
      check("table_blank", 32'(vga_blank_n), 32'h1);
    end

    mode = 2'd3;
    solid_rgb = 24'h123456;
    f = next_frame();
    wait_out(f * FT + pos(0, 1));
    check("solid_before", 32'({vga_r, vga_g, vga_b}), 32'h123456);
    solid_rgb = 24'hABCDEF;
    mode = 2'd1;
    wait_out(f * FT + pos(3, 5));
    check("solid_midframe_held", 32'({vga_r, vga_g, vga_b}), 32'h123456);
    mode = 2'd3;
    wait_out((f + 1) * FT + pos(-1, 0));
    check("solid_porch_blank", 32'({vga_blank_n, vga_r, vga_g, vga_b}), 32'h0);
    wait_out((f + 1) * FT + pos(0, 0));
    check("solid_after", 32'({vga_r, vga_g, vga_b}), 32'hABCDEF);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) solid_rgb = 24'($urandom);
      tick();
    end

    mode = 2'd3;
    f = next_frame();
    wait_out(f * FT + pos(5, 3));
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_hs", 32'(vga_hs), 32'h1);
    check("midreset_vs", 32'(vga_vs), 32'h1);
    check("midreset_out", 32'({vga_blank_n, pix_req, frame_start, vga_r, vga_g, vga_b}), 32'h0);
    check("midreset_pix", 32'({pix_x, pix_y}), 32'h0);
    check("midreset_inv_sync", 32'({i_hs, i_vs}), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    last_fs = -1;
    fmode.delete();
    fsolid.delete();
    for (int i = 0; i < FT + 20; i++) tick();
    check("post_reset_fs_period", 32'(fs_period), 32'(FT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1);
  end

endmodule
